// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, FSM encoding and counter sizing shared by the ALU files
package ula_pkg;
  localparam int OP_ADD   = 0;
  localparam int OP_SHIFT = 1;
  localparam int OP_SUB   = 2;
  localparam int OP_AND   = 3;
  localparam int OP_OR    = 4;
  localparam int OP_MUL   = 5;
  localparam int OP_DIV   = 6;
  typedef enum logic {OCIOSO, ITERA} estado_t;
  function automatic int largura_cnt(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/ula_if.sv
// ula_if: start/ready/valid handshake and operand/result bus of the ALU
interface ula_if #(parameter int WIDTH = 8, parameter int OPW = 3);
  logic inicio;
  logic [OPW-1:0] op;
  logic controle;
  logic [WIDTH-1:0] entrada1;
  logic [WIDTH-1:0] entrada2;
  logic pronto;
  logic valido;
  logic [WIDTH-1:0] saida;
  logic zero;
  logic erro;
  modport master(output inicio, op, controle, entrada1, entrada2, input pronto, valido, saida, zero, erro);
  modport slave(input inicio, op, controle, entrada1, entrada2, output pronto, valido, saida, zero, erro);
endinterface

// File: rtl/ula_iterativa.sv
// ula_iterativa: shift-add multiplier and (with ULA_DIV_EN) restoring divider, WIDTH iterations
module ula_iterativa import ula_pkg::*; #(parameter int WIDTH = 8) (
  input  logic             clock,
  input  logic             reset,
  input  logic             carrega,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             feito,
  output logic [WIDTH-1:0] resultado
);
  localparam int CW = largura_cnt(WIDTH);
  logic [CW-1:0] cnt;
  logic ativo;
  logic [WIDTH-1:0] acc, x, y, p_acc, p_x, p_y;
  assign feito = ativo && cnt == CW'(WIDTH - 1);
`ifdef ULA_DIV_EN
  logic modo;
  logic [WIDTH:0] r_sh;
  logic ge;
  always_ff @(posedge clock)
    if (reset) modo <= 1'b0;
    else if (carrega) modo <= div;
  // acc doubles as the partial remainder; x shifts the dividend out and the quotient in
  always_comb begin
    r_sh = {acc, x[WIDTH-1]};
    ge = r_sh >= {1'b0, y};
    p_acc = modo ? (ge ? r_sh[WIDTH-1:0] - y : r_sh[WIDTH-1:0]) : acc + (y[0] ? x : '0);
    p_x = modo ? {x[WIDTH-2:0], ge} : x << 1;
    p_y = modo ? y : y >> 1;
  end
  assign resultado = modo ? p_x : p_acc;
`else
  logic unused_div;
  assign unused_div = div;
  always_comb begin
    p_acc = acc + (y[0] ? x : '0);
    p_x = x << 1;
    p_y = y >> 1;
  end
  assign resultado = p_acc;
`endif
  // resultado is the value of the final step, so the top can register it on the done edge
  always_ff @(posedge clock)
    if (reset) begin
      cnt <= '0;
      ativo <= 1'b0;
      acc <= '0;
      x <= '0;
      y <= '0;
    end else if (carrega) begin
      cnt <= '0;
      ativo <= 1'b1;
      acc <= '0;
      x <= a;
      y <= b;
    end else if (ativo) begin
      cnt <= cnt + 1'b1;
      ativo <= !feito;
      acc <= p_acc;
      x <= p_x;
      y <= p_y;
    end
endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered ALU with iterative MUL/DIV behind start/ready/valid; DIV needs ULA_DIV_EN
module ula_multiciclo import ula_pkg::*; #(parameter int WIDTH = 8, parameter int OPW = 3) (
  input logic  clock,
  input logic  reset,
  ula_if.slave bus
);
`ifdef ULA_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  estado_t estado, prox;
  logic aceita, itera, feito, erro_imm;
  logic [WIDTH-1:0] imediato, resultado;
  assign bus.pronto = estado == OCIOSO;
  always_comb begin
    aceita = bus.inicio && bus.pronto;
    itera = bus.op == OPW'(OP_MUL) || (DIV_EN && bus.op == OPW'(OP_DIV) && bus.entrada2 != '0);
    prox = estado == OCIOSO ? (aceita && itera ? ITERA : OCIOSO) : (feito ? OCIOSO : ITERA);
    // a DIV reaching this path has B==0; without the divider it falls through to reserved
    imediato = bus.op == OPW'(OP_ADD)   ? bus.entrada1 + bus.entrada2 :
               bus.op == OPW'(OP_SHIFT) ? (bus.controle ? bus.entrada1 << bus.entrada2 : bus.entrada1 >> bus.entrada2) :
               bus.op == OPW'(OP_SUB)   ? bus.entrada1 - bus.entrada2 :
               bus.op == OPW'(OP_AND)   ? bus.entrada1 & bus.entrada2 :
               bus.op == OPW'(OP_OR)    ? bus.entrada1 | bus.entrada2 :
               DIV_EN && bus.op == OPW'(OP_DIV) ? '1 : '0;
    erro_imm = bus.op > OPW'(OP_OR);
  end
  always_ff @(posedge clock)
    if (reset) estado <= OCIOSO;
    else estado <= prox;
  always_ff @(posedge clock)
    if (reset) begin
      bus.saida <= '0;
      bus.zero <= 1'b0;
      bus.erro <= 1'b0;
      bus.valido <= 1'b0;
    end else begin
      bus.valido <= 1'b0;
      if (aceita && !itera) begin
        bus.saida <= imediato;
        bus.zero <= imediato == '0;
        bus.erro <= erro_imm;
        bus.valido <= 1'b1;
      end else if (estado == ITERA && feito) begin
        bus.saida <= resultado;
        bus.zero <= resultado == '0;
        bus.erro <= 1'b0;
        bus.valido <= 1'b1;
      end
    end
  ula_iterativa #(.WIDTH(WIDTH)) u_iter (
    .clock(clock),
    .reset(reset),
    .carrega(aceita && itera),
    .div(bus.op == OPW'(OP_DIV)),
    .a(bus.entrada1),
    .b(bus.entrada2),
    .feito(feito),
    .resultado(resultado)
  );
endmodule
